// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - RS(204,188) code constants, GF(2^8) multiply and generator polynomial
package rs_pkg;
   localparam int RS_N    = 204;
   localparam int RS_K    = 188;
   localparam int RS_NPAR = 16;

   localparam logic [7:0] GF_POLY   = 8'h1D;
   localparam logic [7:0] SLOT_PAR  = 8'(RS_K);
   localparam logic [7:0] SLOT_LAST = 8'(RS_N - 1);

   function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // Expands prod (x + alpha^i), i=0..15; the monic x^16 term is dropped.
   function automatic logic [15:0][7:0] calc_gen();
      logic [16:0][7:0] g;
      logic [7:0]       root;
      g    = '0;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < RS_NPAR; i++) begin
         for (int j = RS_NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mult(root, g[j]);
         g[0] = gf_mult(root, g[0]);
         root = gf_mult(root, 8'h02);
      end
      return g[15:0];
   endfunction

   localparam logic [15:0][7:0] RS_GEN = calc_gen();
endpackage

// File: rtl/gf_mul.sv
// rtl/gf_mul.sv - combinational 8x8 GF(2^8) multiplier, field polynomial 0x11D
module gf_mul
   import rs_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);
   assign p = gf_mult(a, b);
endmodule

// File: rtl/rs_enc.sv
// rtl/rs_enc.sv - systematic RS(204,188) encoder, one symbol per CE strobe
module rs_enc
   import rs_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       CE,
   input  logic [7:0] input_byte,
   output logic       Ready,
   output logic [7:0] Out_byte,
   output logic       CEO,
   output logic       Valid_out
);
   logic [7:0]       slot;
   logic [7:0]       slot_nxt;
   logic             data_slot;
   logic             last_q;
   logic [7:0]       fb;
   logic [15:0][7:0] r;
   logic [15:0][7:0] prod;

   assign data_slot = (slot < SLOT_PAR);
   assign slot_nxt  = (slot == SLOT_LAST) ? 8'h00 : slot + 8'h01;
   assign fb        = input_byte ^ r[15];

   for (genvar i = 0; i < RS_NPAR; i++) begin : g_tap
      gf_mul u_mul (
         .a (fb),
         .b (RS_GEN[i]),
         .p (prod[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot      <= 8'h00;
         r         <= '0;
         Out_byte  <= 8'h00;
         CEO       <= 1'b0;
         Valid_out <= 1'b0;
         Ready     <= 1'b1;
         last_q    <= 1'b0;
      end else begin
         CEO    <= CE;
         last_q <= CE && (slot == SLOT_LAST);
         if (CE) begin
            slot  <= slot_nxt;
            Ready <= (slot_nxt < SLOT_PAR);
            // Parity slots shift zeros in, so the register is clear after slot 203.
            if (data_slot) begin
               Out_byte <= input_byte;
               r        <= {r[14:0], 8'h00} ^ prod;
            end else begin
               Out_byte <= r[15];
               r        <= {r[14:0], 8'h00};
            end
         end
         if (CE && (slot == 8'h00)) Valid_out <= 1'b1;
         else if (last_q)           Valid_out <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rs_enc.sv
// tb/tb_rs_enc.sv - directed scoreboard bench for rs_enc against a long-division model
module tb_rs_enc;
   logic       clk = 1'b0;
   logic       reset;
   logic       CE;
   logic [7:0] input_byte;
   logic       Ready;
   logic [7:0] Out_byte;
   logic       CEO;
   logic       Valid_out;

   rs_enc dut (
      .clk        (clk),
      .reset      (reset),
      .CE         (CE),
      .input_byte (input_byte),
      .Ready      (Ready),
      .Out_byte   (Out_byte),
      .CEO        (CEO),
      .Valid_out  (Valid_out)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         exp_t [256];
   int         log_t [256];
   logic [7:0] gen [17];
   logic [7:0] msg [188];
   logic [7:0] cw [204];
   logic [7:0] exp_q [$];
   int         slot_m;
   bit         valid_m;
   bit         clear_next;
   logic [7:0] last_out;

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic encode();
      logic [7:0] buff [204];
      logic [7:0] c;
      for (int i = 0; i < 204; i++) buff[i] = (i < 188) ? msg[i] : 8'h00;
      for (int i = 0; i < 188; i++) begin
         c = buff[i];
         if (c != 8'h00)
            for (int j = 1; j <= 16; j++) buff[i+j] = buff[i+j] ^ mul(c, gen[16-j]);
      end
      for (int i = 0; i < 204; i++) cw[i] = (i < 188) ? msg[i] : buff[i];
   endtask

   task automatic tick(input logic ce_v, input logic [7:0] din);
      int s;
      logic [7:0] e;
      s = slot_m;
      chk("ready", 8'(Ready), 8'(slot_m < 188));
      CE = ce_v;
      input_byte = din;
      if (ce_v) exp_q.push_back(cw[s]);
      @(posedge clk);
      @(negedge clk);
      CE = 1'b0;
      if (ce_v) begin
         chk("ceo", 8'(CEO), 8'h01);
         e = exp_q.pop_front();
         chk($sformatf("out_slot%0d", s), Out_byte, e);
         last_out = e;
         if (s == 0) valid_m = 1'b1;
         else if (clear_next) valid_m = 1'b0;
         clear_next = (s == 203);
         slot_m = (s == 203) ? 0 : s + 1;
      end else begin
         chk("ceo_idle", 8'(CEO), 8'h00);
         chk("out_hold", Out_byte, last_out);
         if (clear_next) valid_m = 1'b0;
         clear_next = 1'b0;
      end
      chk("valid", 8'(Valid_out), 8'(valid_m));
   endtask

   task automatic send_block(input int spacing, input int count);
      for (int s = 0; s < count; s++) begin
         tick(1'b1, (s < 188) ? msg[s] : 8'($urandom));
         for (int k = 1; k < spacing; k++) tick(1'b0, 8'($urandom));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      CE = 1'b1;
      input_byte = 8'($urandom);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_ceo", 8'(CEO), 8'h00);
      end
      reset = 1'b0;
      CE = 1'b0;
      exp_q.delete();
      slot_m = 0;
      valid_m = 1'b0;
      clear_next = 1'b0;
      last_out = 8'h00;
      chk("rst_out", Out_byte, 8'h00);
      chk("rst_valid", 8'(Valid_out), 8'h00);
      chk("rst_ready", 8'(Ready), 8'h01);
   endtask

   initial begin
      int x;
      reset = 1'b0;
      CE = 1'b0;
      input_byte = 8'h00;
      exp_t[0] = 1;
      log_t[0] = 0;
      log_t[1] = 0;
      for (int i = 1; i < 255; i++) begin
         x = exp_t[i-1] << 1;
         if ((x & 256) != 0) x = x ^ 32'h11D;
         exp_t[i] = x;
         log_t[x] = i;
      end
      for (int i = 0; i < 17; i++) gen[i] = 8'h00;
      gen[0] = 8'h01;
      for (int i = 0; i < 16; i++) begin
         for (int j = 16; j > 0; j--) gen[j] = gen[j-1] ^ mul(8'(exp_t[i]), gen[j]);
         gen[0] = mul(8'(exp_t[i]), gen[0]);
      end

      @(negedge clk);
      do_reset();

      // all-zero block
      for (int i = 0; i < 188; i++) msg[i] = 8'h00;
      for (int i = 0; i < 204; i++) cw[i] = 8'h00;
      send_block(8, 204);

      // impulse at the last data byte yields the generator coefficients
      msg[187] = 8'h01;
      for (int i = 0; i < 204; i++) cw[i] = (i < 188) ? msg[i] : gen[15 - (i - 188)];
      send_block(8, 204);

      // random blocks, each sent at 8-clock and then back-to-back spacing
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 188; i++) msg[i] = 8'($urandom);
         encode();
         send_block(8, 204);
         send_block(1, 204);
      end
      for (int k = 0; k < 3; k++) tick(1'b0, 8'($urandom));

      // abort mid-block, then all-0xFF block
      for (int i = 0; i < 188; i++) msg[i] = 8'($urandom);
      encode();
      send_block(8, 100);
      do_reset();
      for (int i = 0; i < 188; i++) msg[i] = 8'hFF;
      encode();
      send_block(8, 204);
      send_block(1, 204);
      for (int k = 0; k < 3; k++) tick(1'b0, 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
